button_event_queue: RTL and testbench
=====================================

# button_event_queue

Converts the five debounced push-button levels into discrete press events and queues them for the CPU in a small FIFO. Sits between the button debouncers and the CPU's memory-mapped I/O read path. The CPU pops one event code per read strobe, so no press is missed between polls. Overflow is flagged with a sticky bit.

## Interface
- DEPTH, 8, FIFO entries; power of two, 2..64
- PTR_W, 3, log2(DEPTH)
- ext_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- enable  in  1  low = freeze queue, pending mask and overflow; edge history still tracks inputs
- btn_up, btn_left, btn_center, btn_right, btn_down  in  1 each  debounced levels, already synchronous to ext_clk
- rd  in  1  one-cycle pop strobe from CPU I/O decode
- clr_ovf  in  1  clears the overflow flag
- ev_valid  out  1  queue non-empty
- ev_code  out  3  head event code, 0 when empty
- ev_count  out  PTR_W+1  entries held, 0..DEPTH
- overflow  out  1  sticky; an event was dropped

## Operation
- Codes: up=1, left=2, center=3, right=4, down=5. Codes 0, 6 and 7 are never queued.
- Edge history prev[4:0] loads the current button levels every cycle, including during reset and while enable=0.
  - Consequence: a button held through reset release, or through enable going high, produces no event.
- Rise detection: rise = level & ~prev, evaluated only when enable=1.
- Pending mask pend[4:0] holds presses not yet queued.
  - Candidate set: cand = pend | rise.
  - Each enabled cycle, the highest-priority candidate is selected. Priority: up > left > center > right > down.
  - Selected candidate is pushed and its bit cleared. Other candidates stay in pend.
  - A repeated rise of a bit already pending merges; no second event.
- Push when not full: code written at wr_ptr, wr_ptr increments.
- Push when full and no pop this cycle: code dropped, its pend bit cleared, overflow set to 1.
- Pop: rd=1, enable=1 and count>0 → rd_ptr increments. rd while empty is ignored.
- Simultaneous push and pop:
  - Allowed, including when full (pop frees the slot, push succeeds, count unchanged, no overflow).
  - Allowed when count=1 and the push lands in the next slot.
  - Never a same-cycle bypass: if empty at the clock edge, the pop is ignored and the push lands.
- Pointers wrap modulo DEPTH. ev_count is maintained separately to distinguish full from empty.
- overflow: set has priority over clr_ovf in the same cycle. Cleared by reset or by clr_ovf without a concurrent drop.
- Reset: pointers, count and pend cleared, overflow cleared, prev loaded with the current levels.
  - Queue contents are don't-care.
  - Reset mid-operation discards all queued and pending events.

## Timing
- All outputs are registered state or direct decodes of it:
  - ev_valid = (count != 0)
  - ev_code = count ? mem[rd_ptr] : 0
- Reset values: ev_valid=0, ev_code=0, ev_count=0, overflow=0.
- Press latency:
  - Level rises before edge k → entry pushed at edge k → ev_valid=1 and ev_code valid after edge k.
  - With n simultaneous rises, the i-th by priority is pushed at edge k+i (i = 0..n-1).
- Pop: rd sampled at edge j → after edge j, ev_code shows the next entry (or 0) and ev_count is decremented.
- Throughput: one push and one pop per cycle maximum.

## Test plan
- Reset with btn_up held, release reset, hold 5 cycles → ev_count stays 0, ev_valid=0.
- btn_left 0→1 for one cycle, then btn_left 0→1 again later → first push gives ev_code=2, ev_count=1. After the second press, ev_count=2 and ev_code stays 2. rd → ev_code=2, count 1; rd → ev_code=0, ev_valid=0.
- All five buttons rise in the same cycle → over 5 consecutive edges the count goes 1..5. Pops return 1,2,3,4,5 in order.
- Generate 9 distinct presses with DEPTH=8 and no reads → ev_count=8, overflow=1. The 8 entries match the first 8 codes pressed. clr_ovf → overflow=0, queue intact.
- Queue full, rd asserted in the same cycle as a btn_down rise → ev_count stays 8, overflow stays 0, and 5 is the last entry popped.
- 3 entries queued, assert reset for 1 cycle with btn_right held → all outputs 0. Release btn_right, press again → ev_code=4.

Source files
------------

// File: rtl/button_event_queue.sv
// Turns five debounced button levels into priority-ordered press events
// and queues them in a small FIFO that the CPU pops one code per read strobe.
module button_event_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = 3
) (
    input  logic             ext_clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             btn_up,
    input  logic             btn_left,
    input  logic             btn_center,
    input  logic             btn_right,
    input  logic             btn_down,
    input  logic             rd,
    input  logic             clr_ovf,
    output logic             ev_valid,
    output logic [2:0]       ev_code,
    output logic [PTR_W:0]   ev_count,
    output logic             overflow
);

    logic [4:0]       levels;
    logic [4:0]       prev_q, prev_d;
    logic [4:0]       pend_q, pend_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [2:0]       mem_q [DEPTH];

    logic [4:0] rise, cand, sel;
    logic [2:0] sel_code;
    logic       push, pop, full, write, drop;

    // Bit order doubles as priority: bit 0 (up) wins, code = bit index + 1.
    assign levels = {btn_down, btn_right, btn_center, btn_left, btn_up};

    always_comb begin
        rise       = '0;
        cand       = '0;
        sel        = '0;
        sel_code   = '0;
        push       = 1'b0;
        pop        = 1'b0;
        full       = 1'b0;
        write      = 1'b0;
        drop       = 1'b0;
        prev_d     = levels;
        pend_d     = pend_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (enable) begin
            rise = levels & ~prev_q;
            cand = pend_q | rise;
            for (int unsigned i = 0; i < 5; i++) begin
                if (cand[i] && (sel == '0)) begin
                    sel[i]   = 1'b1;
                    sel_code = 3'(i + 1);
                end
            end

            push   = |cand;
            pop    = rd && (count_q != '0);
            full   = (count_q == (PTR_W + 1)'(DEPTH));
            write  = push && (!full || pop);
            drop   = push && full && !pop;
            pend_d = cand & ~sel;

            if (write) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

            if (write && !pop)      count_d = count_q + 1'b1;
            else if (!write && pop) count_d = count_q - 1'b1;

            if (drop)         overflow_d = 1'b1;
            else if (clr_ovf) overflow_d = 1'b0;
        end
    end

    always_ff @(posedge ext_clk) begin
        // Edge history tracks the buttons even in reset so held buttons stay silent.
        prev_q <= prev_d;
        if (reset) begin
            pend_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (write) mem_q[wr_ptr_q] <= sel_code;
        end
    end

    assign ev_valid = (count_q != '0);
    assign ev_code  = ev_valid ? mem_q[rd_ptr_q] : 3'd0;
    assign ev_count = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_button_event_queue.sv
// Directed bench for button_event_queue: each task drives one scenario and
// checks registered outputs 1 ns after the rising edge.
module tb_button_event_queue;

    logic       ext_clk = 1'b0;
    logic       reset, enable, rd, clr_ovf;
    logic       btn_up, btn_left, btn_center, btn_right, btn_down;
    logic       ev_valid, overflow;
    logic [2:0] ev_code;
    logic [3:0] ev_count;

    int checks   = 0;
    int failures = 0;

    always #5 ext_clk = ~ext_clk;

    button_event_queue #(.DEPTH(8), .PTR_W(3)) dut (
        .ext_clk(ext_clk), .reset(reset), .enable(enable),
        .btn_up(btn_up), .btn_left(btn_left), .btn_center(btn_center),
        .btn_right(btn_right), .btn_down(btn_down),
        .rd(rd), .clr_ovf(clr_ovf),
        .ev_valid(ev_valid), .ev_code(ev_code), .ev_count(ev_count),
        .overflow(overflow)
    );

    task automatic tick();
        @(posedge ext_clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_down, btn_right, btn_center, btn_left, btn_up} = b;
    endtask

    // One press: rise for one cycle, then release for one cycle.
    task automatic press(input int code);
        logic [4:0] b;
        b = 5'b00001 << (code - 1);
        set_btns(b);
        tick();
        set_btns(5'b0);
        tick();
    endtask

    task automatic test_reset();
        set_btns(5'b00001);
        reset = 1'b1;
        tick(); tick();
        checks++;
        if ({ev_valid, ev_code, ev_count, overflow} !== 9'b0) begin
            failures++;
            $display("FAIL reset_values got valid=%0b code=%0d count=%0d ovf=%0b want all 0",
                     ev_valid, ev_code, ev_count, overflow);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (ev_count !== 4'd0 || ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL held_through_reset got count=%0d valid=%0b want 0 0", ev_count, ev_valid);
        end
        set_btns(5'b0);
        tick();
    endtask

    task automatic test_merge_and_pop();
        btn_left = 1'b1; tick();
        checks++;
        if (ev_code !== 3'd2 || ev_count !== 4'd1) begin
            failures++;
            $display("FAIL left_first got code=%0d count=%0d want 2 1", ev_code, ev_count);
        end
        btn_left = 1'b0; tick();
        btn_left = 1'b1; tick();
        btn_left = 1'b0;
        checks++;
        if (ev_code !== 3'd2 || ev_count !== 4'd2) begin
            failures++;
            $display("FAIL left_second got code=%0d count=%0d want 2 2", ev_code, ev_count);
        end
        rd = 1'b1; tick(); rd = 1'b0;
        checks++;
        if (ev_code !== 3'd2 || ev_count !== 4'd1) begin
            failures++;
            $display("FAIL left_pop1 got code=%0d count=%0d want 2 1", ev_code, ev_count);
        end
        rd = 1'b1; tick();
        checks++;
        if (ev_code !== 3'd0 || ev_valid !== 1'b0) begin
            failures++;
            $display("FAIL left_pop2 got code=%0d valid=%0b want 0 0", ev_code, ev_valid);
        end
        tick(); rd = 1'b0;
        checks++;
        if (ev_count !== 4'd0) begin
            failures++;
            $display("FAIL rd_empty got count=%0d want 0", ev_count);
        end
    endtask

    task automatic test_all_five();
        set_btns(5'b11111);
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if (ev_count !== 4'(i) || ev_code !== 3'd1) begin
                failures++;
                $display("FAIL all5_fill[%0d] got count=%0d head=%0d want %0d 1",
                         i, ev_count, ev_code, i);
            end
        end
        set_btns(5'b0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (ev_code !== 3'(i)) begin
                failures++;
                $display("FAIL all5_pop[%0d] got code=%0d want %0d", i, ev_code, i);
            end
            rd = 1'b1; tick(); rd = 1'b0;
        end
        checks++;
        if (ev_valid !== 1'b0 || ev_count !== 4'd0) begin
            failures++;
            $display("FAIL all5_empty got valid=%0b count=%0d want 0 0", ev_valid, ev_count);
        end
    endtask

    task automatic test_overflow();
        int seq [9] = '{1, 2, 3, 4, 5, 1, 2, 3, 4};
        for (int i = 0; i < 9; i++) press(seq[i]);
        checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_full got count=%0d ovf=%0b want 8 1", ev_count, overflow);
        end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || ev_count !== 4'd8) begin
            failures++;
            $display("FAIL ovf_clear got ovf=%0b count=%0d want 0 8", overflow, ev_count);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_code !== 3'(seq[i])) begin
                failures++;
                $display("FAIL ovf_entry[%0d] got code=%0d want %0d", i, ev_code, seq[i]);
            end
            rd = 1'b1; tick(); rd = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int fill [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
        int rest [8] = '{2, 3, 4, 1, 2, 3, 4, 5};
        for (int i = 0; i < 8; i++) press(fill[i]);
        btn_down = 1'b1; rd = 1'b1; tick();
        btn_down = 1'b0; rd = 1'b0;
        checks++;
        if (ev_count !== 4'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop got count=%0d ovf=%0b want 8 0", ev_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (ev_code !== 3'(rest[i])) begin
                failures++;
                $display("FAIL full_drain[%0d] got code=%0d want %0d", i, ev_code, rest[i]);
            end
            rd = 1'b1; tick(); rd = 1'b0;
        end
    endtask

    task automatic test_enable_freeze();
        enable = 1'b0;
        btn_up = 1'b1; tick();
        checks++;
        if (ev_count !== 4'd0) begin
            failures++;
            $display("FAIL disabled_press got count=%0d want 0", ev_count);
        end
        enable = 1'b1; tick(); tick();
        checks++;
        if (ev_count !== 4'd0) begin
            failures++;
            $display("FAIL held_through_enable got count=%0d want 0", ev_count);
        end
        btn_up = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        press(1); press(2); press(3);
        checks++;
        if (ev_count !== 4'd3) begin
            failures++;
            $display("FAIL mid_prefill got count=%0d want 3", ev_count);
        end
        btn_right = 1'b1; reset = 1'b1; tick(); reset = 1'b0;
        checks++;
        if ({ev_valid, ev_code, ev_count, overflow} !== 9'b0) begin
            failures++;
            $display("FAIL mid_reset got valid=%0b code=%0d count=%0d ovf=%0b want all 0",
                     ev_valid, ev_code, ev_count, overflow);
        end
        tick();
        checks++;
        if (ev_count !== 4'd0) begin
            failures++;
            $display("FAIL mid_held got count=%0d want 0", ev_count);
        end
        btn_right = 1'b0; tick();
        btn_right = 1'b1; tick(); btn_right = 1'b0;
        checks++;
        if (ev_code !== 3'd4 || ev_count !== 4'd1) begin
            failures++;
            $display("FAIL mid_repress got code=%0d count=%0d want 4 1", ev_code, ev_count);
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; rd = 1'b0; clr_ovf = 1'b0;
        set_btns(5'b0);
        test_reset();
        test_merge_and_pop();
        test_all_five();
        test_overflow();
        test_back_to_back();
        test_enable_freeze();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
